// File: rtl/tomasulo_rs_bank_if.sv
// Bundle of issue, CDB, dispatch and status signals for one reservation-station bank.
//   issue_*  : renamed op from issue (valid/ready)
//   cdb_*    : common data bus broadcast snooped by the bank
//   disp_*   : ready op presented to the functional unit (valid/ready)
//   flush    : synchronous clear of every entry
//   busy_vec, count, dbg_state : status / debug view of the bank
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid never depends on ready; once disp_valid is raised the
// presented op stays frozen until disp_ready (except on flush).
// Modports: master = issue/FU side driving stimulus, slave = the bank.
interface tomasulo_rs_bank_if #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 3,
    parameter int IDX_W  = $clog2(DEPTH)
);
    logic              flush;
    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [TAG_W-1:0]  issue_qj;
    logic [TAG_W-1:0]  issue_qk;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]  issue_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [DATA_W-1:0] disp_vj;
    logic [DATA_W-1:0] disp_vk;
    logic [TAG_W-1:0]  disp_tag;
    logic [IDX_W-1:0]  disp_idx;
    logic [DEPTH-1:0]  busy_vec;
    logic [IDX_W:0]    count;
    logic              dbg_state;

    modport master (
        output flush, issue_valid, issue_op, issue_qj, issue_qk, issue_vj, issue_vk, issue_tag,
        output cdb_valid, cdb_tag, cdb_data, disp_ready,
        input  issue_ready, disp_valid, disp_op, disp_vj, disp_vk, disp_tag, disp_idx,
        input  busy_vec, count, dbg_state
    );

    modport slave (
        input  flush, issue_valid, issue_op, issue_qj, issue_qk, issue_vj, issue_vk, issue_tag,
        input  cdb_valid, cdb_tag, cdb_data, disp_ready,
        output issue_ready, disp_valid, disp_op, disp_vj, disp_vk, disp_tag, disp_idx,
        output busy_vec, count, dbg_state
    );
endinterface

// File: rtl/tomasulo_rs_bank.sv
// Parametrised Tomasulo reservation-station bank (one per FU class).
// Holds renamed ops, snoops the CDB for pending source tags and dispatches one
// ready op per cycle to its functional unit.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tomasulo_rs_bank_if.slave (issue, CDB, dispatch, flush, status)
// Optional feature macro: RS_AGE_ORDER_EN -- when defined, ready entries are
// selected oldest-first (ties to lowest index); otherwise lowest ready index.
// Dispatch FSM states (visible on bus.dbg_state): 0 = SEL, 1 = HOLD.
module tomasulo_rs_bank #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tomasulo_rs_bank_if.slave     bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    typedef enum logic {SEL = 1'b0, HOLD = 1'b1} disp_state_e;

    logic [DEPTH-1:0]  busy_q;
    logic [OP_W-1:0]   op_q  [DEPTH];
    logic [TAG_W-1:0]  qj_q  [DEPTH];
    logic [TAG_W-1:0]  qk_q  [DEPTH];
    logic [DATA_W-1:0] vj_q  [DEPTH];
    logic [DATA_W-1:0] vk_q  [DEPTH];
    logic [TAG_W-1:0]  tag_q [DEPTH];
    logic [IDX_W:0]    count_q;
    disp_state_e       state_q, state_d;
    logic [IDX_W-1:0]  hold_idx_q;

`ifdef RS_AGE_ORDER_EN
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(DEPTH-1);
    logic [IDX_W-1:0]  age_q [DEPTH];
    logic [IDX_W-1:0]  best_age;
`endif

    logic              cdb_hit;
    logic [DEPTH-1:0]  rdy;
    logic              sel_any;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  free_idx;
    logic              accept;
    logic              disp_valid_c;
    logic [IDX_W-1:0]  disp_idx_c;
    logic              fire;
    logic [TAG_W-1:0]  new_qj, new_qk;
    logic [DATA_W-1:0] new_vj, new_vk;

    // Tag 0 means "no producer", so a tag-0 broadcast can never wake anything.
    assign cdb_hit = bus.cdb_valid && (bus.cdb_tag != '0);

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            rdy[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end

    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
`ifdef RS_AGE_ORDER_EN
        best_age = '0;
        // Ascending scan with strict '>' keeps the lowest index on equal ages.
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] && (!sel_any || (age_q[i] > best_age))) begin
                sel_any  = 1'b1;
                sel_idx  = IDX_W'(i);
                best_age = age_q[i];
            end
        end
`else
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (rdy[i]) begin
                sel_any = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
`endif
    end

    // Lowest free slot from registered busy flags only: a slot freed by this
    // cycle's dispatch is not visible until the next cycle.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (!busy_q[i]) free_idx = IDX_W'(i);
    end

    assign bus.issue_ready = (count_q < FULL_CNT) && !bus.flush;
    assign accept          = bus.issue_valid && bus.issue_ready;

    // Same-cycle CDB bypass for incoming operands.
    always_comb begin
        new_qj = bus.issue_qj;
        new_vj = bus.issue_vj;
        new_qk = bus.issue_qk;
        new_vk = bus.issue_vk;
        if (cdb_hit && (bus.issue_qj == bus.cdb_tag)) begin
            new_qj = '0;
            new_vj = bus.cdb_data;
        end
        if (cdb_hit && (bus.issue_qk == bus.cdb_tag)) begin
            new_qk = '0;
            new_vk = bus.cdb_data;
        end
    end

    // Dispatch FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEL;
            hold_idx_q <= '0;
        end else begin
            state_q <= state_d;
            // Tracks the selection while in SEL so the index is locked on entry to HOLD.
            if (state_q == SEL) hold_idx_q <= sel_idx;
        end
    end

    // Dispatch FSM: next state.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = SEL;
        end else begin
            case (state_q)
                SEL:     if (disp_valid_c && !bus.disp_ready) state_d = HOLD;
                HOLD:    if (bus.disp_ready) state_d = SEL;
                default: state_d = SEL;
            endcase
        end
    end

    // Dispatch FSM: outputs. HOLD ignores newly ready entries until accepted.
    always_comb begin
        disp_idx_c   = (state_q == HOLD) ? hold_idx_q : sel_idx;
        disp_valid_c = !bus.flush && ((state_q == HOLD) || sel_any);
    end

    assign fire = disp_valid_c && bus.disp_ready;

    assign bus.disp_valid = disp_valid_c;
    assign bus.disp_idx   = disp_valid_c ? disp_idx_c        : '0;
    assign bus.disp_op    = disp_valid_c ? op_q[disp_idx_c]  : '0;
    assign bus.disp_vj    = disp_valid_c ? vj_q[disp_idx_c]  : '0;
    assign bus.disp_vk    = disp_valid_c ? vk_q[disp_idx_c]  : '0;
    assign bus.disp_tag   = disp_valid_c ? tag_q[disp_idx_c] : '0;
    assign bus.busy_vec   = busy_q;
    assign bus.count      = count_q;
    assign bus.dbg_state  = state_q;

    // Entry storage, CDB capture, issue write and dispatch free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                tag_q[i] <= '0;
`ifdef RS_AGE_ORDER_EN
                age_q[i] <= '0;
`endif
            end
        end else if (bus.flush) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_hit && busy_q[i] && (qj_q[i] == bus.cdb_tag)) begin
                    vj_q[i] <= bus.cdb_data;
                    qj_q[i] <= '0;
                end
                if (cdb_hit && busy_q[i] && (qk_q[i] == bus.cdb_tag)) begin
                    vk_q[i] <= bus.cdb_data;
                    qk_q[i] <= '0;
                end
`ifdef RS_AGE_ORDER_EN
                if (accept && busy_q[i] && (age_q[i] != AGE_MAX))
                    age_q[i] <= age_q[i] + 1'b1;
`endif
            end
            // free_idx is never busy and disp_idx_c always is, so these never collide.
            if (fire) busy_q[disp_idx_c] <= 1'b0;
            if (accept) begin
                busy_q[free_idx] <= 1'b1;
                op_q[free_idx]   <= bus.issue_op;
                tag_q[free_idx]  <= bus.issue_tag;
                qj_q[free_idx]   <= new_qj;
                qk_q[free_idx]   <= new_qk;
                vj_q[free_idx]   <= new_vj;
                vk_q[free_idx]   <= new_vk;
`ifdef RS_AGE_ORDER_EN
                age_q[free_idx]  <= '0;
`endif
            end
            case ({accept, fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_tomasulo_rs_bank.sv
// Directed self-checking bench for tomasulo_rs_bank (DEPTH=4).
// Expected dispatches are pushed to exp_q when ops are issued and popped when
// the bank hands an op to the FU; status signals are checked at directed points.
module tb_tomasulo_rs_bank;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int OP_W   = 3;
    localparam int IDX_W  = 2;
    localparam int W      = OP_W + 2*DATA_W + TAG_W + IDX_W;

    localparam logic [OP_W-1:0] FP_ADD = 3'd0;
    localparam logic [OP_W-1:0] FP_SUB = 3'd1;
    localparam logic [OP_W-1:0] FP_MUL = 3'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [W-1:0] exp_q[$];

    tomasulo_rs_bank_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    tomasulo_rs_bank #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic logic [W-1:0] mk(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] vj,
                                        input logic [DATA_W-1:0] vk, input logic [TAG_W-1:0] tag,
                                        input logic [IDX_W-1:0] idx);
        return {op, vj, vk, tag, idx};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_issue(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] qj,
                             input logic [TAG_W-1:0] qk, input logic [DATA_W-1:0] vj,
                             input logic [DATA_W-1:0] vk, input logic [TAG_W-1:0] tag);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_qj    = qj;
        bus.issue_qk    = qk;
        bus.issue_vj    = vj;
        bus.issue_vk    = vk;
        bus.issue_tag   = tag;
    endtask

    task automatic clr_issue();
        bus.issue_valid = 1'b0;
        bus.issue_op    = $urandom_range(7, 0);
        bus.issue_qj    = '0;
        bus.issue_qk    = '0;
        bus.issue_vj    = $urandom_range(255, 0);
        bus.issue_vk    = $urandom_range(255, 0);
        bus.issue_tag   = '0;
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    task automatic clr_cdb();
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = '0;
        bus.cdb_data  = '0;
    endtask

    // One clock: sample the dispatch handshake just before the edge, then
    // return 1 time unit after the edge, where the next inputs are driven.
    task automatic step();
        logic [W-1:0] e;
        #2;
        if (bus.disp_valid && bus.disp_ready) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("disp", {bus.disp_op, bus.disp_vj, bus.disp_vk, bus.disp_tag, bus.disp_idx}, e);
            end else begin
                check("spurious_disp", bus.disp_valid, 1'b0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.flush      = 1'b0;
        bus.disp_ready = 1'b0;
        clr_issue();
        clr_cdb();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // T1 reset state
        check("rst_busy",   bus.busy_vec, 4'b0000);
        check("rst_count",  bus.count, 3'd0);
        check("rst_iready", bus.issue_ready, 1'b1);
        check("rst_dvalid", bus.disp_valid, 1'b0);
        check("rst_state",  bus.dbg_state, 1'b0);
        check("rst_dvj",    bus.disp_vj, 32'd0);
        @(posedge clk);
        #1;

        // T2 zero-dependency op
        bus.disp_ready = 1'b1;
        set_issue(FP_ADD, 0, 0, 32'd10, 32'd20, 4'd1);
        exp_q.push_back(mk(FP_ADD, 32'd10, 32'd20, 4'd1, 2'd0));
        step();
        clr_issue();
        check("t2_dvalid", bus.disp_valid, 1'b1);
        check("t2_dvj",    bus.disp_vj, 32'd10);
        check("t2_dvk",    bus.disp_vk, 32'd20);
        check("t2_dtag",   bus.disp_tag, 4'd1);
        check("t2_count1", bus.count, 3'd1);
        step();
        check("t2_count0", bus.count, 3'd0);
        check("t2_busy0",  bus.busy_vec, 4'b0000);

        // T3a wakeup through the CDB two cycles after issue
        set_issue(FP_SUB, 4'd3, 0, 32'd0, 32'd20, 4'd2);
        exp_q.push_back(mk(FP_SUB, 32'd30, 32'd20, 4'd2, 2'd0));
        step();
        clr_issue();
        step();
        check("t3_wait", bus.disp_valid, 1'b0);
        set_cdb(4'd3, 32'd30);
        step();
        clr_cdb();
        check("t3_wake_valid", bus.disp_valid, 1'b1);
        check("t3_wake_vj",    bus.disp_vj, 32'd30);
        step();

        // T3b same-cycle CDB bypass at issue
        set_issue(FP_MUL, 4'd5, 0, 32'd0, 32'd3, 4'd4);
        set_cdb(4'd5, 32'd7);
        exp_q.push_back(mk(FP_MUL, 32'd7, 32'd3, 4'd4, 2'd0));
        step();
        clr_issue();
        clr_cdb();
        check("t3_byp_valid", bus.disp_valid, 1'b1);
        check("t3_byp_vj",    bus.disp_vj, 32'd7);
        step();
        check("t3_q_empty", exp_q.size(), 0);

        // T4 fill the bank, hold a fifth request, wake all four with one broadcast
        for (int i = 0; i < DEPTH; i++) begin
            set_issue(FP_ADD, 4'd2, 0, 32'd0, 32'(i + 1), 4'(5 + i));
            exp_q.push_back(mk(FP_ADD, 32'h22, 32'(i + 1), 4'(5 + i), 2'(i)));
            step();
        end
        check("t4_iready_full", bus.issue_ready, 1'b0);
        check("t4_count_full",  bus.count, 3'd4);
        check("t4_busy_full",   bus.busy_vec, 4'b1111);
        set_issue(FP_ADD, 0, 0, 32'd1, 32'd1, 4'd9);
        step();
        clr_issue();
        check("t4_held_count", bus.count, 3'd4);
        set_cdb(4'd2, 32'h22);
        step();
        clr_cdb();
        repeat (DEPTH) step();
        check("t4_q_empty", exp_q.size(), 0);
        check("t4_count0",  bus.count, 3'd0);

        // T5 backpressure: idx2 held while idx0 becomes ready
        bus.disp_ready = 1'b0;
        set_issue(FP_ADD, 4'd9, 0, 32'd0, 32'd1, 4'd1);
        step();
        set_issue(FP_SUB, 4'd10, 0, 32'd0, 32'd2, 4'd2);
        step();
        set_issue(FP_MUL, 0, 0, 32'd5, 32'd6, 4'd3);
        exp_q.push_back(mk(FP_MUL, 32'd5, 32'd6, 4'd3, 2'd2));
        exp_q.push_back(mk(FP_ADD, 32'h99, 32'd1, 4'd1, 2'd0));
        step();
        clr_issue();
        check("t5_first_idx", bus.disp_idx, 2'd2);
        set_cdb(4'd9, 32'h99);
        step();
        clr_cdb();
        for (int c = 0; c < 2; c++) begin
            check("t5_hold_state", bus.dbg_state, 1'b1);
            check("t5_hold_idx",   bus.disp_idx, 2'd2);
            check("t5_hold_vj",    bus.disp_vj, 32'd5);
            step();
        end
        check("t5_hold_idx_last", bus.disp_idx, 2'd2);
        bus.disp_ready = 1'b1;
        step();
        check("t5_next_idx", bus.disp_idx, 2'd0);
        step();
        check("t5_q_empty", exp_q.size(), 0);
        check("t5_count1",  bus.count, 3'd1);

        // T6 flush with simultaneous CDB and issue, from the HOLD state
        bus.disp_ready = 1'b0;
        set_issue(FP_ADD, 0, 0, 32'h44, 32'd4, 4'd4);
        step();
        set_issue(FP_SUB, 4'd12, 0, 32'd0, 32'd5, 4'd5);
        step();
        clr_issue();
        check("t6_busy3",  bus.busy_vec, 4'b0111);
        check("t6_count3", bus.count, 3'd3);
        check("t6_hold",   bus.dbg_state, 1'b1);
        bus.flush = 1'b1;
        set_cdb(4'd10, 32'h55);
        set_issue(FP_ADD, 0, 0, 32'd1, 32'd1, 4'd6);
        #1;
        check("t6_flush_dvalid", bus.disp_valid, 1'b0);
        check("t6_flush_iready", bus.issue_ready, 1'b0);
        step();
        bus.flush = 1'b0;
        clr_issue();
        clr_cdb();
        check("t6_count0", bus.count, 3'd0);
        check("t6_busy0",  bus.busy_vec, 4'b0000);
        check("t6_dvalid", bus.disp_valid, 1'b0);
        check("t6_state",  bus.dbg_state, 1'b0);
        bus.disp_ready = 1'b1;
        step();
        check("t6_after_dvalid", bus.disp_valid, 1'b0);

        // T7 selection order after an entry is freed and reissued
        set_issue(FP_ADD, 4'd3, 0, 32'd0, 32'd1, 4'd1);
        step();
        set_issue(FP_SUB, 4'd13, 0, 32'd0, 32'd2, 4'd2);
        step();
        clr_issue();
        set_cdb(4'd3, 32'h33);
        exp_q.push_back(mk(FP_ADD, 32'h33, 32'd1, 4'd1, 2'd0));
        step();
        clr_cdb();
        step();
        set_issue(FP_MUL, 4'd13, 0, 32'd0, 32'd3, 4'd3);
        step();
        clr_issue();
        check("t7_reissue_busy", bus.busy_vec, 4'b0011);
`ifdef RS_AGE_ORDER_EN
        exp_q.push_back(mk(FP_SUB, 32'hD, 32'd2, 4'd2, 2'd1));
        exp_q.push_back(mk(FP_MUL, 32'hD, 32'd3, 4'd3, 2'd0));
`else
        exp_q.push_back(mk(FP_MUL, 32'hD, 32'd3, 4'd3, 2'd0));
        exp_q.push_back(mk(FP_SUB, 32'hD, 32'd2, 4'd2, 2'd1));
`endif
        set_cdb(4'd13, 32'hD);
        step();
        clr_cdb();
        step();
        step();
        check("t7_q_empty", exp_q.size(), 0);
        check("t7_count0",  bus.count, 3'd0);

        // Asynchronous reset in the middle of a cycle drops live entries
        set_issue(FP_ADD, 4'd15, 0, 32'd0, 32'd1, 4'd7);
        step();
        clr_issue();
        check("ar_busy_before", bus.busy_vec, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy",   bus.busy_vec, 4'b0000);
        check("ar_count",  bus.count, 3'd0);
        check("ar_iready", bus.issue_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("ar_dvalid", bus.disp_valid, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
